// File: rtl/periph_bus_bridge_if.sv
// Core-side and peripheral-side signals of the peripheral bus bridge.
interface periph_bus_bridge_if #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned SLOT_SHIFT = 12
);
  // Core data port
  logic [31:0]               m_addr;
  logic [31:0]               m_wdata;
  logic [2:0]                m_flag;
  logic                      m_we;
  logic                      m_re;
  logic [31:0]               m_rdata;
  logic                      m_ready;
  logic                      m_err;
  // Peripheral slots
  logic [NUM_SLAVES-1:0]     s_sel;
  logic [SLOT_SHIFT-1:0]     s_addr;
  logic [31:0]               s_wdata;
  logic [2:0]                s_flag;
  logic                      s_we;
  logic                      s_re;
  logic [32*NUM_SLAVES-1:0]  s_rdata;
  logic [NUM_SLAVES-1:0]     s_ready;
  // Error capture
  logic [31:0]               err_addr;
  logic                      err_valid;
  logic                      err_clr;

  // Environment side: the core plus the peripherals driving the bridge.
  modport master (
    output m_addr, m_wdata, m_flag, m_we, m_re, s_rdata, s_ready, err_clr,
    input  m_rdata, m_ready, m_err, s_sel, s_addr, s_wdata, s_flag, s_we, s_re,
           err_addr, err_valid
  );

  // Bridge side.
  modport slave (
    input  m_addr, m_wdata, m_flag, m_we, m_re, s_rdata, s_ready, err_clr,
    output m_rdata, m_ready, m_err, s_sel, s_addr, s_wdata, s_flag, s_we, s_re,
           err_addr, err_valid
  );
endinterface

// File: rtl/periph_bus_bridge.sv
// Registered router from the core data port to NUM_SLAVES peripheral slots,
// with per-slave wait states, a timeout watchdog and sticky error capture.
module periph_bus_bridge #(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter logic [31:0] PERIPH_BASE    = 32'h4000_0000,
  parameter int unsigned SLOT_SHIFT     = 12,
  parameter int unsigned WINDOW_SHIFT   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  periph_bus_bridge_if.slave bus
);

  localparam int unsigned SLOT_W = WINDOW_SHIFT - SLOT_SHIFT;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [2:0]            flag_q, flag_d;
  logic                  we_q, we_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  ready_q, ready_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic                  s_we_q, s_we_d;
  logic                  s_re_q, s_re_d;
  logic                  err_valid_q, err_valid_d;
  logic [31:0]           err_addr_q, err_addr_d;

  logic [SLOT_W-1:0]     req_slot_c;
  logic                  in_window_c;
  logic                  req_c;
  logic                  slot_ok_c;
  logic [NUM_SLAVES-1:0] req_onehot_c;
  logic                  sel_ready_c;
  logic [31:0]           sel_rdata_c;
  logic                  timeout_c;
  logic                  err_set_c;
  logic [31:0]           err_src_c;

  // Request decode: window hit and slot lookup on the live master address.
  assign req_slot_c  = bus.m_addr[WINDOW_SHIFT-1:SLOT_SHIFT];
  assign in_window_c = (bus.m_addr[31:WINDOW_SHIFT] == PERIPH_BASE[31:WINDOW_SHIFT]);
  assign req_c       = in_window_c & (bus.m_we | bus.m_re);
  assign slot_ok_c   = (32'(req_slot_c) < NUM_SLAVES);
  assign timeout_c   = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // One-hot select for the requested slot and ready/rdata mux for the latched one.
  always_comb begin
    req_onehot_c = '0;
    sel_ready_c  = 1'b0;
    sel_rdata_c  = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      req_onehot_c[i] = (req_slot_c == SLOT_W'(i));
      if (slot_q == SLOT_W'(i)) begin
        sel_ready_c = bus.s_ready[i];
        sel_rdata_c = bus.s_rdata[32*i +: 32];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_c) state_d = slot_ok_c ? ST_ACTIVE : ST_RESP;
      end
      ST_ACTIVE: begin
        if (sel_ready_c || timeout_c) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; every bus output is a register.
  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    flag_d      = flag_q;
    we_d        = we_q;
    slot_d      = slot_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    ready_d     = 1'b0;
    sel_d       = sel_q;
    s_we_d      = s_we_q;
    s_re_d      = s_re_q;
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    err_set_c   = 1'b0;
    err_src_c   = addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          addr_d  = bus.m_addr;
          wdata_d = bus.m_wdata;
          flag_d  = bus.m_flag;
          we_d    = bus.m_we;
          slot_d  = req_slot_c;
          if (slot_ok_c) begin
            cnt_d  = '0;
            sel_d  = req_onehot_c;
            s_we_d = bus.m_we;
            s_re_d = ~bus.m_we;
          end else begin
            ready_d   = 1'b1;
            err_d     = 1'b1;
            rdata_d   = '0;
            err_set_c = 1'b1;
            err_src_c = bus.m_addr;
          end
        end
      end
      ST_ACTIVE: begin
        if (sel_ready_c) begin
          ready_d = 1'b1;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : sel_rdata_c;
          sel_d   = '0;
          s_we_d  = 1'b0;
          s_re_d  = 1'b0;
        end else if (timeout_c) begin
          ready_d   = 1'b1;
          err_d     = 1'b1;
          rdata_d   = '0;
          sel_d     = '0;
          s_we_d    = 1'b0;
          s_re_d    = 1'b0;
          err_set_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        sel_d  = '0;
        s_we_d = 1'b0;
        s_re_d = 1'b0;
      end
      default: ;
    endcase

    // A new capture outranks a simultaneous clear.
    if (err_set_c && (!err_valid_q || bus.err_clr)) begin
      err_valid_d = 1'b1;
      err_addr_d  = err_src_c;
    end else if (bus.err_clr) begin
      err_valid_d = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      flag_q      <= '0;
      we_q        <= 1'b0;
      slot_q      <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
      sel_q       <= '0;
      s_we_q      <= 1'b0;
      s_re_q      <= 1'b0;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      flag_q      <= flag_d;
      we_q        <= we_d;
      slot_q      <= slot_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      sel_q       <= sel_d;
      s_we_q      <= s_we_d;
      s_re_q      <= s_re_d;
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign bus.m_rdata   = rdata_q;
  assign bus.m_ready   = ready_q;
  assign bus.m_err     = err_q;
  assign bus.s_sel     = sel_q;
  assign bus.s_addr    = addr_q[SLOT_SHIFT-1:0];
  assign bus.s_wdata   = wdata_q;
  assign bus.s_flag    = flag_q;
  assign bus.s_we      = s_we_q;
  assign bus.s_re      = s_re_q;
  assign bus.err_addr  = err_addr_q;
  assign bus.err_valid = err_valid_q;

endmodule

// File: tb/tb_periph_bus_bridge.sv
// Directed bench for periph_bus_bridge: 4 slots, 8-cycle timeout.
module tb_periph_bus_bridge;

  logic clk;
  logic rst;
  int   n_asserts = 0;
  int   n_fail    = 0;

  periph_bus_bridge_if #(.NUM_SLAVES(4), .SLOT_SHIFT(12)) bif ();

  periph_bus_bridge #(
    .NUM_SLAVES    (4),
    .PERIPH_BASE   (32'h4000_0000),
    .SLOT_SHIFT    (12),
    .WINDOW_SHIFT  (16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; checks and drives happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bif.m_addr   = '0;
    bif.m_wdata  = '0;
    bif.m_flag   = '0;
    bif.m_we     = 1'b0;
    bif.m_re     = 1'b0;
    bif.s_rdata  = {32'h3333_3333, 32'h2222_2222, 32'hA5A5_1234, 32'h1111_1111};
    bif.s_ready  = '0;
    bif.err_clr  = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_m_ready",   32'(bif.m_ready),   32'h0);
    chk("rst_m_err",     32'(bif.m_err),     32'h0);
    chk("rst_m_rdata",   bif.m_rdata,        32'h0);
    chk("rst_s_sel",     32'(bif.s_sel),     32'h0);
    chk("rst_s_we",      32'(bif.s_we),      32'h0);
    chk("rst_s_re",      32'(bif.s_re),      32'h0);
    chk("rst_s_addr",    32'(bif.s_addr),    32'h0);
    chk("rst_err_valid", 32'(bif.err_valid), 32'h0);
    chk("rst_err_addr",  bif.err_addr,       32'h0);
    rst = 1'b0;
    tick();

    // Zero-wait read of slot 1
    bif.m_addr = 32'h4000_1004;
    bif.m_re   = 1'b1;
    tick();
    bif.m_re   = 1'b0;
    bif.m_addr = '0;
    chk("rd1_s_sel",   32'(bif.s_sel),   32'h2);
    chk("rd1_s_addr",  32'(bif.s_addr),  32'h004);
    chk("rd1_s_re",    32'(bif.s_re),    32'h1);
    chk("rd1_s_we",    32'(bif.s_we),    32'h0);
    chk("rd1_early",   32'(bif.m_ready), 32'h0);
    bif.s_ready = 4'b0010;
    tick();
    bif.s_ready = '0;
    chk("rd1_m_ready", 32'(bif.m_ready), 32'h1);
    chk("rd1_m_rdata", bif.m_rdata,      32'hA5A5_1234);
    chk("rd1_m_err",   32'(bif.m_err),   32'h0);
    chk("rd1_resp_sel", 32'(bif.s_sel),  32'h0);
    chk("rd1_resp_re", 32'(bif.s_re),    32'h0);
    tick();
    chk("rd1_pulse",   32'(bif.m_ready), 32'h0);

    // Timeout on slot 0 while the other slots claim ready
    bif.m_addr  = 32'h4000_0008;
    bif.m_re    = 1'b1;
    bif.s_ready = 4'b1110;
    tick();
    bif.m_re = 1'b0;
    chk("to1_s_sel", 32'(bif.s_sel), 32'h1);
    chk("to1_s_re",  32'(bif.s_re),  32'h1);
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk("to1_wait", 32'(bif.m_ready), 32'h0);
    end
    tick();
    chk("to1_m_ready",   32'(bif.m_ready),   32'h1);
    chk("to1_m_err",     32'(bif.m_err),     32'h1);
    chk("to1_m_rdata",   bif.m_rdata,        32'h0);
    chk("to1_s_sel",     32'(bif.s_sel),     32'h0);
    chk("to1_err_valid", 32'(bif.err_valid), 32'h1);
    chk("to1_err_addr",  bif.err_addr,       32'h4000_0008);
    tick();

    // Second timeout keeps the first captured address
    bif.m_addr  = 32'h4000_2000;
    bif.m_re    = 1'b1;
    bif.s_ready = 4'b1011;
    tick();
    bif.m_re = 1'b0;
    repeat (7) tick();
    chk("to2_wait", 32'(bif.m_ready), 32'h0);
    tick();
    chk("to2_m_ready",   32'(bif.m_ready),   32'h1);
    chk("to2_m_err",     32'(bif.m_err),     32'h1);
    chk("to2_err_valid", 32'(bif.err_valid), 32'h1);
    chk("to2_err_addr",  bif.err_addr,       32'h4000_0008);
    bif.s_ready = '0;
    tick();

    // Unmapped slot 5 with err_clr in the same cycle: capture wins
    bif.m_addr  = 32'h4000_5000;
    bif.m_re    = 1'b1;
    bif.err_clr = 1'b1;
    tick();
    bif.m_re    = 1'b0;
    bif.err_clr = 1'b0;
    chk("um_m_ready",   32'(bif.m_ready),   32'h1);
    chk("um_m_err",     32'(bif.m_err),     32'h1);
    chk("um_s_sel",     32'(bif.s_sel),     32'h0);
    chk("um_s_re",      32'(bif.s_re),      32'h0);
    chk("um_err_valid", 32'(bif.err_valid), 32'h1);
    chk("um_err_addr",  bif.err_addr,       32'h4000_5000);
    tick();
    chk("um_pulse", 32'(bif.m_ready), 32'h0);
    bif.err_clr = 1'b1;
    tick();
    bif.err_clr = 1'b0;
    chk("clr_err_valid", 32'(bif.err_valid), 32'h0);

    // Write slot 3 with five wait cycles; unselected ready is ignored
    bif.m_addr  = 32'h4000_3010;
    bif.m_wdata = 32'hCAFE_F00D;
    bif.m_flag  = 3'b101;
    bif.m_we    = 1'b1;
    tick();
    bif.m_we    = 1'b0;
    bif.m_wdata = '0;
    bif.m_flag  = '0;
    bif.s_ready = 4'b0111;
    chk("wr_s_addr", 32'(bif.s_addr), 32'h010);
    chk("wr_s_flag", 32'(bif.s_flag), 32'h5);
    for (int k = 1; k <= 6; k++) begin
      chk("wr_s_we",    32'(bif.s_we),    32'h1);
      chk("wr_s_wdata", bif.s_wdata,      32'hCAFE_F00D);
      chk("wr_s_sel",   32'(bif.s_sel),   32'h8);
      chk("wr_wait",    32'(bif.m_ready), 32'h0);
      if (k == 6) bif.s_ready = 4'b1000;
      tick();
    end
    bif.s_ready = '0;
    chk("wr_m_ready", 32'(bif.m_ready), 32'h1);
    chk("wr_m_err",   32'(bif.m_err),   32'h0);
    chk("wr_m_rdata", bif.m_rdata,      32'h0);
    chk("wr_s_we_off", 32'(bif.s_we),   32'h0);
    tick();

    // Out-of-window request held for several cycles is ignored
    bif.m_addr = 32'h1000_0000;
    bif.m_re   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ow_s_sel",   32'(bif.s_sel),   32'h0);
      chk("ow_s_re",    32'(bif.s_re),    32'h0);
      chk("ow_m_ready", 32'(bif.m_ready), 32'h0);
    end
    bif.m_re = 1'b0;
    tick();

    // Both we and re on slot 0 is issued as a write
    bif.m_addr  = 32'h4000_0020;
    bif.m_wdata = 32'h1234_5678;
    bif.m_we    = 1'b1;
    bif.m_re    = 1'b1;
    tick();
    bif.m_we = 1'b0;
    bif.m_re = 1'b0;
    chk("wr2_s_we",    32'(bif.s_we),  32'h1);
    chk("wr2_s_re",    32'(bif.s_re),  32'h0);
    chk("wr2_s_sel",   32'(bif.s_sel), 32'h1);
    chk("wr2_s_wdata", bif.s_wdata,    32'h1234_5678);
    bif.s_ready = 4'b0001;
    tick();
    bif.s_ready = '0;
    chk("wr2_m_ready", 32'(bif.m_ready), 32'h1);
    chk("wr2_m_rdata", bif.m_rdata,      32'h0);
    tick();

    // Reset in the second ACTIVE cycle aborts the access
    bif.m_addr = 32'h4000_2100;
    bif.m_re   = 1'b1;
    tick();
    bif.m_re = 1'b0;
    tick();
    chk("ab_s_re_live", 32'(bif.s_re), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ab_s_sel",   32'(bif.s_sel),   32'h0);
    chk("ab_s_re",    32'(bif.s_re),    32'h0);
    chk("ab_m_ready", 32'(bif.m_ready), 32'h0);
    tick();
    chk("ab_no_pulse", 32'(bif.m_ready), 32'h0);

    // Fresh read of slot 2 after the abort
    bif.m_re = 1'b1;
    tick();
    bif.m_re = 1'b0;
    chk("rd2_s_sel",  32'(bif.s_sel),  32'h4);
    chk("rd2_s_addr", 32'(bif.s_addr), 32'h100);
    bif.s_ready = 4'b0100;
    tick();
    bif.s_ready = '0;
    chk("rd2_m_ready", 32'(bif.m_ready), 32'h1);
    chk("rd2_m_rdata", bif.m_rdata,      32'h2222_2222);
    chk("rd2_m_err",   32'(bif.m_err),   32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/periph_bus_bridge.md
# periph_bus_bridge

Parametrised data-bus bridge between the core's data port and up to `NUM_SLAVES` memory-mapped peripherals (UART, GPIO, timer, PWM and future blocks). It replaces per-peripheral address self-decode with one registered router that provides:
- slot decode;
- a per-slave ready handshake, so slaves may insert wait states;
- a bus-timeout watchdog;
- a sticky error-capture register.

It sits between the core/memory-controller data path and the peripheral slots, and has its own clock domain `clk`.

## Interface
Parameters:
- `NUM_SLAVES`, 4, number of peripheral slots (1..16)
- `PERIPH_BASE`, 32'h40000000, base of the peripheral window
- `SLOT_SHIFT`, 12, log2 of the slot size (4 KiB slots)
- `WINDOW_SHIFT`, 16, log2 of the total window size; window = [`PERIPH_BASE`, `PERIPH_BASE` + 2^`WINDOW_SHIFT`)
- `TIMEOUT_CYCLES`, 255, maximum number of ACTIVE cycles before a bus error (≥1)

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset
- `m_addr`  in  32  master byte address
- `m_wdata`  in  32  master write data
- `m_flag`  in  3  access size/sign flag, passed through unchanged
- `m_we`  in  1  write request
- `m_re`  in  1  read request
- `m_rdata`  out  32  read data; valid when `m_ready`=1
- `m_ready`  out  1  one-cycle completion pulse
- `m_err`  out  1  completion carries an error; only meaningful with `m_ready`
- `s_sel`  out  `NUM_SLAVES`  one-hot slot select
- `s_addr`  out  `SLOT_SHIFT`  offset within the slot
- `s_wdata`  out  32  latched write data
- `s_flag`  out  3  latched flag
- `s_we`  out  1  write strobe to the selected slave
- `s_re`  out  1  read strobe to the selected slave
- `s_rdata`  in  32*`NUM_SLAVES`  slave read data; slot i occupies bits [32i+31:32i]
- `s_ready`  in  `NUM_SLAVES`  slave completion, sampled only for the selected slot
- `err_addr`  out  32  address of the first captured error
- `err_valid`  out  1  sticky error flag
- `err_clr`  in  1  clears `err_valid`

## Operation
The FSM has three states: IDLE, ACTIVE, RESP.

**IDLE**
- Samples `m_we | m_re` only when `m_addr` is inside the window. Requests outside the window are ignored; other targets serve them.
- On an accepted request, latches addr, wdata, flag and direction. If `m_we` and `m_re` are both set, the access is a write.
- Slot = `m_addr[WINDOW_SHIFT-1:SLOT_SHIFT]`.
- Slot < `NUM_SLAVES`: go to ACTIVE and clear the timeout counter.
- Slot ≥ `NUM_SLAVES`: go straight to RESP with error set. No slave strobe is issued.

**ACTIVE**
- `s_sel[slot]`=1. `s_we` or `s_re` is held high together with the latched `s_addr`, `s_wdata` and `s_flag`.
- When `s_ready[slot]`=1: capture `s_rdata` slice `slot` (writes capture 0), error=0, go to RESP.
- Otherwise the counter increments. When counter == `TIMEOUT_CYCLES`-1 and there is still no ready: error=1, rdata=0, go to RESP.
- `s_ready` of unselected slots is ignored.

**RESP**
- `m_ready`=1 for exactly one cycle, with registered `m_rdata` and `m_err`. All `s_*` strobes and `s_sel` are 0.
- Always returns to IDLE.
- The master must change or drop its request in the cycle after `m_ready`. A request still held in IDLE is treated as a new access.

**Error capture**
- On entry to RESP with error, if `err_valid`=0: set `err_valid` and latch `err_addr` = the faulting address.
- Later errors do not overwrite `err_addr` while `err_valid`=1.
- If `err_clr` and a new error capture occur in the same cycle, the capture wins: `err_valid` stays 1 and `err_addr` takes the new address.

## Timing
- Reset values: state IDLE, counter 0, all outputs 0 (including `m_ready`, `m_err`, `s_sel`, `err_valid`, `err_addr`).
- Reset mid-transaction aborts it: no `m_ready` pulse, and strobes drop the cycle after `rst` is sampled.
- Request accepted in cycle T:
  - ACTIVE in T+1.
  - A zero-wait slave (`s_ready` high in T+1) gives `m_ready` in T+2, so minimum latency is 2 cycles.
  - A slave with N wait cycles gives `m_ready` at T+2+N.
- Timeout: `m_ready`/`m_err` at T+1+`TIMEOUT_CYCLES`.
- Unmapped slot: `m_ready`/`m_err` at T+1.
- Counter width is $clog2(`TIMEOUT_CYCLES`+1) bits. It does not wrap, because it is cleared on entry to ACTIVE.
- Back-to-back accesses: the earliest next acceptance is the cycle after RESP, i.e. a 3-cycle issue rate.

## Test plan
- Read slot 1 (`m_addr`=0x40001004, slave drives 0xA5A5_1234 with `s_ready` in the first ACTIVE cycle) -> `s_sel`=4'b0010, `s_addr`=0x004, `m_ready` at T+2, `m_rdata`=0xA5A5_1234, `m_err`=0.
- Write slot 3 (0x40003010, wdata 0xCAFE_F00D, slave waits 5 cycles) -> `s_we` held 6 cycles with stable data; `m_ready` at T+7, `m_err`=0.
- Read 0x4000_5000 (slot 5 ≥ `NUM_SLAVES`) -> no `s_sel`; `m_ready` and `m_err` at T+1; `err_valid`=1, `err_addr`=0x4000_5000.
- Slave never ready, `TIMEOUT_CYCLES`=8 -> `m_ready`/`m_err` at T+9, `m_rdata`=0. A second timeout at 0x40002000 leaves `err_addr` at the first address. `err_clr` asserted together with a third error captures the third address.
- `m_addr`=0x1000_0000 with `m_re` -> no response and no strobes. `m_we` and `m_re` both set on slot 0 -> a write is issued.
- `rst` asserted in the 2nd ACTIVE cycle -> `s_sel`/`s_re` become 0 the next cycle, no `m_ready`, state IDLE. A fresh read then completes normally.
